// File: rtl/debounce_edge_det_if.sv
// ============================================================================
// Module   : debounce_edge_det_if
// Purpose  : Signal bundle between a debounce/edge-detect block and its user.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debounce_edge_det_if #(
  parameter int CNT_W = 8
);
  logic             d_i;
  logic             cnt_clr_i;
  logic             level_o;
  logic             rise_o;
  logic             fall_o;
  logic [CNT_W-1:0] edge_cnt_o;
  logic             cnt_sat_o;

  modport master (
    output d_i,
    output cnt_clr_i,
    input  level_o,
    input  rise_o,
    input  fall_o,
    input  edge_cnt_o,
    input  cnt_sat_o
  );

  modport slave (
    input  d_i,
    input  cnt_clr_i,
    output level_o,
    output rise_o,
    output fall_o,
    output edge_cnt_o,
    output cnt_sat_o
  );
endinterface

`default_nettype wire

// File: rtl/debounce_edge_det.sv
// ============================================================================
// Module   : debounce_edge_det
// Purpose  : Synchronise, debounce and edge-detect one raw asynchronous input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_edge_det #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  debounce_edge_det_if.slave   bus
);

  localparam int          c_CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
  localparam bit          c_ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  logic [c_CW-1:0]        r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic [CNT_W-1:0]       w_edge_cnt_nxt;
  logic                   r_sat;

  // ------------------------------------------------------------------------
  // Synchroniser chain: bit 0 captures the raw input.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.d_i};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // ------------------------------------------------------------------------
  // Debounce FSM. r_cnt counts consecutive samples of w_s that disagree with
  // the accepted level; a disagreeing run of DEBOUNCE_CYCLES flips the level.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_LOW: begin
          if (w_s) begin
            if (c_ONE_SHOT) begin
              r_state <= ST_HIGH;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_RISE_PEND;
              r_cnt   <= c_ONE;
            end
          end
        end
        ST_RISE_PEND: begin
          if (!w_s) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == c_LAST) begin
            r_state <= ST_HIGH;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        ST_HIGH: begin
          if (!w_s) begin
            if (c_ONE_SHOT) begin
              r_state <= ST_LOW;
              r_level <= 1'b0;
              r_fall  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_FALL_PEND;
              r_cnt   <= c_ONE;
            end
          end
        end
        ST_FALL_PEND: begin
          if (w_s) begin
            r_state <= ST_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == c_LAST) begin
            r_state <= ST_LOW;
            r_level <= 1'b0;
            r_fall  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        default: begin
          r_state <= ST_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Rising-edge counter. A clear coinciding with a rise pulse keeps that edge.
  // ------------------------------------------------------------------------
  always_comb begin
    w_edge_cnt_nxt = r_edge_cnt;
    if (bus.cnt_clr_i) begin
      w_edge_cnt_nxt = r_rise ? CNT_W'(1) : '0;
    end else if (r_rise && !(&r_edge_cnt)) begin
      w_edge_cnt_nxt = r_edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_edge_cnt <= w_edge_cnt_nxt;
      r_sat      <= &w_edge_cnt_nxt;
    end
  end

  assign bus.level_o    = r_level;
  assign bus.rise_o     = r_rise;
  assign bus.fall_o     = r_fall;
  assign bus.edge_cnt_o = r_edge_cnt;
  assign bus.cnt_sat_o  = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_debounce_edge_det.sv
// ============================================================================
// Module   : tb_debounce_edge_det
// Purpose  : Directed self-checking bench for debounce_edge_det.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debounce_edge_det;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  debounce_edge_det_if #(.CNT_W(8)) bus0 ();
  debounce_edge_det_if #(.CNT_W(2)) bus1 ();

  debounce_edge_det #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  debounce_edge_det #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(2)) u_dut_w2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus0.d_i = 1'b0; bus0.cnt_clr_i = 1'b0;
    bus1.d_i = 1'b0; bus1.cnt_clr_i = 1'b0;
    step(); step();
    n_cmp++;
    if ({bus0.level_o, bus0.rise_o, bus0.fall_o, bus0.edge_cnt_o, bus0.cnt_sat_o} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_dut0: got %0h expected 0",
               {bus0.level_o, bus0.rise_o, bus0.fall_o, bus0.edge_cnt_o, bus0.cnt_sat_o});
    end
    n_cmp++;
    if ({bus1.level_o, bus1.rise_o, bus1.fall_o, bus1.edge_cnt_o, bus1.cnt_sat_o} !== 6'h0) begin
      n_err++;
      $display("FAIL reset_dut1: got %0h expected 0",
               {bus1.level_o, bus1.rise_o, bus1.fall_o, bus1.edge_cnt_o, bus1.cnt_sat_o});
    end
    reset = 1'b1;
  endtask

  // d_i low for 4 cycles, then high: level rises after the 6th edge.
  task automatic test_rise();
    repeat (4) begin
      step();
      n_cmp++;
      if (bus0.level_o !== 1'b0) begin
        n_err++;
        $display("FAIL rise_idle_level: got %b expected 0", bus0.level_o);
      end
    end
    bus0.d_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++;
      if ({bus0.level_o, bus0.rise_o, bus0.fall_o} !== {(i == 6), (i == 6), 1'b0}) begin
        n_err++;
        $display("FAIL rise_edge%0d lvl/rise/fall: got %b expected %b", i,
                 {bus0.level_o, bus0.rise_o, bus0.fall_o}, {(i == 6), (i == 6), 1'b0});
      end
    end
    step();
    n_cmp++;
    if ({bus0.level_o, bus0.rise_o, bus0.edge_cnt_o, bus0.cnt_sat_o} !== {1'b1, 1'b0, 8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL rise_after lvl/rise/cnt/sat: got %0h expected %0h",
               {bus0.level_o, bus0.rise_o, bus0.edge_cnt_o, bus0.cnt_sat_o},
               {1'b1, 1'b0, 8'd1, 1'b0});
    end
  endtask

  task automatic test_fall();
    bus0.d_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++;
      if ({bus0.level_o, bus0.rise_o, bus0.fall_o} !== {(i != 6), 1'b0, (i == 6)}) begin
        n_err++;
        $display("FAIL fall_edge%0d lvl/rise/fall: got %b expected %b", i,
                 {bus0.level_o, bus0.rise_o, bus0.fall_o}, {(i != 6), 1'b0, (i == 6)});
      end
    end
    step();
    n_cmp++;
    if ({bus0.fall_o, bus0.edge_cnt_o} !== {1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL fall_after fall/cnt: got %0h expected %0h",
               {bus0.fall_o, bus0.edge_cnt_o}, {1'b0, 8'd1});
    end
  endtask

  // Three cycles high is one sample short of acceptance.
  task automatic test_glitch();
    bus0.d_i = 1'b1;
    repeat (3) step();
    bus0.d_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({bus0.level_o, bus0.rise_o, bus0.fall_o} !== 3'b000) begin
        n_err++;
        $display("FAIL glitch_cyc%0d lvl/rise/fall: got %b expected 000", i,
                 {bus0.level_o, bus0.rise_o, bus0.fall_o});
      end
    end
    n_cmp++;
    if (bus0.edge_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL glitch_cnt: got %0d expected 1", bus0.edge_cnt_o);
    end
  endtask

  task automatic test_clear();
    bus0.d_i = 1'b1;
    repeat (6) step();
    n_cmp++;
    if (bus0.rise_o !== 1'b1) begin
      n_err++;
      $display("FAIL clear_rise_pulse: got %b expected 1", bus0.rise_o);
    end
    bus0.cnt_clr_i = 1'b1;
    step();
    bus0.cnt_clr_i = 1'b0;
    n_cmp++;
    if (bus0.edge_cnt_o !== 8'd1) begin
      n_err++;
      $display("FAIL clear_with_rise: got %0d expected 1", bus0.edge_cnt_o);
    end
    bus0.cnt_clr_i = 1'b1;
    step();
    bus0.cnt_clr_i = 1'b0;
    n_cmp++;
    if ({bus0.level_o, bus0.edge_cnt_o} !== {1'b1, 8'd0}) begin
      n_err++;
      $display("FAIL clear_alone lvl/cnt: got %0h expected %0h",
               {bus0.level_o, bus0.edge_cnt_o}, {1'b1, 8'd0});
    end
    bus0.d_i = 1'b0;
    repeat (8) step();
    n_cmp++;
    if ({bus0.level_o, bus0.edge_cnt_o} !== {1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL clear_return_low lvl/cnt: got %0h expected 0",
               {bus0.level_o, bus0.edge_cnt_o});
    end
  endtask

  // Narrow counter: 1,2,3 then holds at 3 with saturation flagged.
  task automatic test_saturate();
    logic [1:0] exp_tab [4];
    exp_tab = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int e = 0; e < 4; e++) begin
      bus1.d_i = 1'b1;
      repeat (8) step();
      n_cmp++;
      if ({bus1.level_o, bus1.edge_cnt_o, bus1.cnt_sat_o} !== {1'b1, exp_tab[e], (e >= 2)}) begin
        n_err++;
        $display("FAIL sat_edge%0d lvl/cnt/sat: got %0h expected %0h", e + 1,
                 {bus1.level_o, bus1.edge_cnt_o, bus1.cnt_sat_o},
                 {1'b1, exp_tab[e], (e >= 2)});
      end
      bus1.d_i = 1'b0;
      repeat (8) step();
      n_cmp++;
      if (bus1.level_o !== 1'b0) begin
        n_err++;
        $display("FAIL sat_low%0d lvl: got %b expected 0", e + 1, bus1.level_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus0.d_i = 1'b1;
    repeat (8) step();
    bus0.d_i = 1'b0;
    repeat (8) step();
    n_cmp++;
    if ({bus0.level_o, bus0.edge_cnt_o} !== {1'b0, 8'd1}) begin
      n_err++;
      $display("FAIL rmid_setup lvl/cnt: got %0h expected %0h",
               {bus0.level_o, bus0.edge_cnt_o}, {1'b0, 8'd1});
    end
    bus0.d_i = 1'b1;
    repeat (4) step();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus0.level_o, bus0.rise_o, bus0.fall_o, bus0.edge_cnt_o, bus0.cnt_sat_o} !== 12'h0) begin
      n_err++;
      $display("FAIL rmid_async_clear: got %0h expected 0",
               {bus0.level_o, bus0.rise_o, bus0.fall_o, bus0.edge_cnt_o, bus0.cnt_sat_o});
    end
    step(); step();
    n_cmp++;
    if ({bus0.level_o, bus0.rise_o, bus0.edge_cnt_o} !== 10'h0) begin
      n_err++;
      $display("FAIL rmid_held: got %0h expected 0",
               {bus0.level_o, bus0.rise_o, bus0.edge_cnt_o});
    end
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_cmp++;
      if ({bus0.level_o, bus0.rise_o} !== {(i == 6), (i == 6)}) begin
        n_err++;
        $display("FAIL rmid_edge%0d lvl/rise: got %b expected %b", i,
                 {bus0.level_o, bus0.rise_o}, {(i == 6), (i == 6)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_clear();
    test_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
